// File: rtl/fft_pkt_pkg.sv
// Shared types for the FFT frame packetizer.
//   pkt_state_e : framing FSM states (IDLE, RUN, STOPPING)
//   pkt_marks_t : packet markers carried alongside each sample
//   clog2       : ceil(log2(n)), never less than 1, for counter sizing
package fft_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } pkt_state_e;

    typedef struct packed {
        logic sop;
        logic eop;
    } pkt_marks_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fft_st_skid_buffer.sv
// Generic 2-entry Avalon-ST register slice.
//   clk_i, srst_i         : clock, synchronous active-high reset
//   s_valid_i / s_data_i  : sink side beat
//   s_ready_o             : sink ready, registered (high while fewer than 2 entries held)
//   m_valid_o / m_data_o  : source side beat, held stable while stalled
//   m_ready_i             : source side ready
//   empty_o               : no entries held
module fft_st_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             empty_o
);

    // head_q is always the beat presented downstream; tail_q is the skid slot.
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push      = s_valid_i & ready_q;
    assign pop       = (count_q != 2'd0) & m_ready_i;
    assign s_ready_o = ready_q;
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = head_q;
    assign empty_o   = (count_q == 2'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = s_data_i;
                end else begin
                    tail_d = s_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the incoming beat goes behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = s_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = s_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Ready looks at next occupancy so it never depends on downstream ready combinationally.
            ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/fft_frame_packetizer.sv
// Cuts a continuous {real, imag} sample stream into FFT_LENGTH-beat
// Avalon-ST packets. Framing starts and stops only on frame boundaries.
//   clock_clk, reset_reset       : clock, synchronous active-high reset
//   asi_in_data/valid/ready      : unframed sample sink (ready registered)
//   aso_out_data/valid/sop/eop   : framed sample source
//   aso_out_ready                : downstream ready
//   frame_enable                 : level request to frame
//   busy                         : framing active or beats still buffered
//   frame_count                  : frames whose EOP has been emitted (wraps)
module fft_frame_packetizer
    import fft_pkt_pkg::*;
#(
    parameter int INPUT_SYMBOL_WIDTH = 16,
    parameter int FFT_LENGTH         = 1024
) (
    input  logic                            clock_clk,
    input  logic                            reset_reset,
    input  logic [2*INPUT_SYMBOL_WIDTH-1:0] asi_in_data,
    input  logic                            asi_in_valid,
    output logic                            asi_in_ready,
    output logic [2*INPUT_SYMBOL_WIDTH-1:0] aso_out_data,
    output logic                            aso_out_valid,
    output logic                            aso_out_startofpacket,
    output logic                            aso_out_endofpacket,
    input  logic                            aso_out_ready,
    input  logic                            frame_enable,
    output logic                            busy,
    output logic [31:0]                     frame_count
);

    localparam int DATA_WIDTH  = 2 * INPUT_SYMBOL_WIDTH;
    localparam int COUNT_WIDTH = clog2(FFT_LENGTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(FFT_LENGTH - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        pkt_marks_t            marks;
    } pkt_beat_t;

    localparam int BEAT_WIDTH = $bits(pkt_beat_t);

    pkt_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   idle_q;
    logic [31:0]            frame_count_q;

    logic      framed;
    logic      skid_s_valid;
    logic      skid_s_ready;
    logic      skid_m_valid;
    logic      skid_empty;
    logic      push;
    logic      is_last;
    logic      emit_eop;
    pkt_beat_t in_beat;
    pkt_beat_t out_beat;

    // In IDLE the source is never stalled; its beats are simply dropped.
    assign asi_in_ready = idle_q | skid_s_ready;
    assign framed       = (state_q != IDLE);
    assign skid_s_valid = asi_in_valid & framed;
    assign push         = skid_s_valid & skid_s_ready;
    assign is_last      = (cnt_q == LAST_IDX);

    assign in_beat.data      = asi_in_data;
    assign in_beat.marks.sop = (cnt_q == '0);
    assign in_beat.marks.eop = is_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (push) begin
            cnt_d = is_last ? '0 : cnt_q + COUNT_WIDTH'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (frame_enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // An EOP taken in the same cycle enable drops already ends the frame.
                if (!frame_enable) begin
                    state_d = (push && is_last) ? IDLE : STOPPING;
                end
            end
            STOPPING: begin
                // Re-enable wins over EOP so framing continues back-to-back.
                if (frame_enable) begin
                    state_d = RUN;
                end else if (push && is_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign emit_eop = skid_m_valid & aso_out_ready & out_beat.marks.eop;

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idle_q        <= 1'b0;
            frame_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= (state_d == IDLE);
            if (emit_eop) begin
                frame_count_q <= frame_count_q + 32'd1;
            end
        end
    end

    fft_st_skid_buffer #(
        .WIDTH(BEAT_WIDTH)
    ) u_skid (
        .clk_i    (clock_clk),
        .srst_i   (reset_reset),
        .s_valid_i(skid_s_valid),
        .s_data_i (in_beat),
        .s_ready_o(skid_s_ready),
        .m_valid_o(skid_m_valid),
        .m_data_o (out_beat),
        .m_ready_i(aso_out_ready),
        .empty_o  (skid_empty)
    );

    assign aso_out_data          = out_beat.data;
    assign aso_out_valid         = skid_m_valid;
    assign aso_out_startofpacket = skid_m_valid & out_beat.marks.sop;
    assign aso_out_endofpacket   = skid_m_valid & out_beat.marks.eop;
    assign busy                  = framed | ~skid_empty;
    assign frame_count           = frame_count_q;

endmodule

// File: tb/tb_fft_frame_packetizer.sv
// Scoreboard bench for fft_frame_packetizer with FFT_LENGTH = 8.
module tb_fft_frame_packetizer;

    localparam int SW = 16;
    localparam int DW = 2 * SW;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          reset_reset;
    logic [DW-1:0] asi_in_data;
    logic          asi_in_valid;
    logic          asi_in_ready;
    logic [DW-1:0] aso_out_data;
    logic          aso_out_valid;
    logic          aso_out_startofpacket;
    logic          aso_out_endofpacket;
    logic          aso_out_ready;
    logic          frame_enable;
    logic          busy;
    logic [31:0]   frame_count;

    always #5 clk = ~clk;

    fft_frame_packetizer #(
        .INPUT_SYMBOL_WIDTH(SW),
        .FFT_LENGTH(N)
    ) dut (
        .clock_clk            (clk),
        .reset_reset          (reset_reset),
        .asi_in_data          (asi_in_data),
        .asi_in_valid         (asi_in_valid),
        .asi_in_ready         (asi_in_ready),
        .aso_out_data         (aso_out_data),
        .aso_out_valid        (aso_out_valid),
        .aso_out_startofpacket(aso_out_startofpacket),
        .aso_out_endofpacket  (aso_out_endofpacket),
        .aso_out_ready        (aso_out_ready),
        .frame_enable         (frame_enable),
        .busy                 (busy),
        .frame_count          (frame_count)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t          exp_q[$];
    int            tests_run    = 0;
    int            tests_failed = 0;
    int            cyc          = 0;
    int            exp_fc       = 0;
    int            pushed       = 0;
    int            popped       = 0;
    int            rdy_mode     = 0;   // 0: ready held 1, 1: random, 2: held 0
    bit            framing      = 1'b0;
    int            idx          = 0;
    logic [DW-1:0] next_d       = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Downstream ready pattern, updated just after every rising edge.
    initial begin
        aso_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       aso_out_ready = 1'b1;
                1:       aso_out_ready = 1'($urandom_range(0, 1));
                default: aso_out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every emitted beat.
    initial begin
        exp_t          e;
        logic          stalled;
        logic [DW+1:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (reset_reset) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("stall_valid", 64'(aso_out_valid), 64'(1));
                check("stall_beat", 64'({aso_out_data, aso_out_startofpacket, aso_out_endofpacket}), 64'(held));
            end
            if (aso_out_valid && aso_out_ready) begin
                check("frame_count", 64'(frame_count), 64'(exp_fc));
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_emit: got data %0h sop %0b eop %0b, required no output",
                             aso_out_data, aso_out_startofpacket, aso_out_endofpacket);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    $display("[TB] emit data=%0h sop=%0b eop=%0b", aso_out_data,
                             aso_out_startofpacket, aso_out_endofpacket);
                    check("out_beat", 64'({aso_out_data, aso_out_startofpacket, aso_out_endofpacket}),
                          64'({e.d, e.sop, e.eop}));
                    if (e.lat) check("latency", 64'(cyc), 64'(e.cyc));
                    if (e.eop) exp_fc++;
                end
            end
            stalled = aso_out_valid && !aso_out_ready;
            held    = {aso_out_data, aso_out_startofpacket, aso_out_endofpacket};
        end
    end

    // Framing model applied to every accepted beat.
    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        if (framing) begin
            e.d   = d;
            e.sop = (idx == 0);
            e.eop = (idx == N - 1);
            e.cyc = cyc;
            e.lat = (rdy_mode == 0);
            exp_q.push_back(e);
            pushed++;
            if (idx == N - 1) begin
                idx = 0;
                if (!frame_enable) framing = 1'b0;
            end else begin
                idx++;
            end
        end
    endtask

    task automatic idle_cycle();
        asi_in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d);
        int w;
        bit acc;
        w            = 0;
        acc          = 1'b0;
        asi_in_valid = 1'b1;
        asi_in_data  = d;
        forever begin
            if (framing) check("in_ready_vs_occupancy", 64'(asi_in_ready), 64'((pushed - popped) < 2));
            acc = asi_in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            w++;
            if (w > 64) begin
                tests_run++;
                tests_failed++;
                $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", w);
                break;
            end
        end
        asi_in_valid = 1'b0;
        if (acc) model_accept(d);
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            drive_beat(next_d);
            next_d = next_d + 1'b1;
        end
    endtask

    task automatic start_framing();
        frame_enable = 1'b1;
        idle_cycle();
        idle_cycle();
        framing = 1'b1;
        idx     = 0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
        idle_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(asi_in_ready), 64'(0));
        check({tag, "_out_valid"}, 64'(aso_out_valid), 64'(0));
        check({tag, "_sop"}, 64'(aso_out_startofpacket), 64'(0));
        check({tag, "_eop"}, 64'(aso_out_endofpacket), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_frame_count"}, 64'(frame_count), 64'(0));
        check({tag, "_data"}, 64'(aso_out_data), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset  = 1'b1;
        frame_enable = 1'b0;
        asi_in_valid = 1'b0;
        asi_in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_reset = 1'b0;
        check("ready_before_edge", 64'(asi_in_ready), 64'(0));
        @(posedge clk);
        #1;
        check("ready_rise", 64'(asi_in_ready), 64'(1));

        // Continuous ramp, two back-to-back frames.
        start_framing();
        send(16);
        drain();
        check("frame_count_16", 64'(frame_count), 64'(2));

        // Enable dropped mid-frame: frame completes, then IDLE discards.
        send(3);
        frame_enable = 1'b0;
        send(5);
        check("stop_model_idle", 64'(framing), 64'(0));
        drain();
        check("stop_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 4; i++) begin
            check("idle_in_ready", 64'(asi_in_ready), 64'(1));
            drive_beat(next_d);
            next_d = next_d + 1'b1;
            check("idle_out_valid", 64'(aso_out_valid), 64'(0));
        end

        // Random downstream stalls over three frames.
        rdy_mode = 1;
        start_framing();
        send(24);
        drain();
        rdy_mode = 0;
        idle_cycle();

        // Enable dropped and re-raised before EOP: framing continues.
        send(3);
        frame_enable = 1'b0;
        send(2);
        frame_enable = 1'b1;
        send(5);
        frame_enable = 1'b0;
        for (int i = 0; i < 16 && framing; i++) send(1);
        drain();
        check("reraise_busy", 64'(busy), 64'(0));

        // Input gaps: one idle cycle in every three.
        start_framing();
        frame_enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            send(1);
            if (i % 2 == 1) idle_cycle();
        end
        drain();
        check("gaps_busy", 64'(busy), 64'(0));

        // Reset mid-frame with a full skid.
        rdy_mode = 2;
        start_framing();
        send(2);
        check("in_ready_full", 64'(asi_in_ready), 64'(0));
        check("busy_full", 64'(busy), 64'(1));
        reset_reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        exp_fc  = 0;
        pushed  = 0;
        popped  = 0;
        framing = 1'b0;
        idx     = 0;
        rdy_mode    = 0;
        reset_reset = 1'b0;
        start_framing();
        frame_enable = 1'b0;
        send(N);
        drain();
        check("frame_count_after_reset", 64'(frame_count), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
